mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-ported memory (the cell-state RAM) among four requesters: typically the generation engine's read side, its write side, the video scan-out and the host loader. It grants one requester at a time, drives the 2-bit select of the address/data `mux_4x1` path, and bounds every grant with a hold limit so no requester can starve the others. It sits between the requester blocks and the RAM wrapper.

---
 rtl/life_pkg.sv | 25 ++
 rtl/mux_4x1.sv | 31 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// ============================================================================
// Module      : life_pkg
// Description : Shared types and constants for the cell-state RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package life_pkg;

  localparam int ARB_N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic [1:0] REQ_GEN_RD = 2'd0;
  localparam logic [1:0] REQ_GEN_WR = 2'd1;
  localparam logic [1:0] REQ_VIDEO  = 2'd2;
  localparam logic [1:0] REQ_HOST   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mux_4x1.sv
// ============================================================================
// Module      : mux_4x1
// Description : Four-input one-hot-free binary-select multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4x1 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter with per-tenure hold limit sharing one RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import life_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int HOLD_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ARB_N_REQ-1:0]  req,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [ADDR_WIDTH-1:0] addr3,
  output logic [ARB_N_REQ-1:0]  gnt,
  output logic [1:0]            select,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  busy
);

  localparam int                 c_CNT_W     = $clog2(HOLD_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_MAX - 1);

  arb_state_t                  r_state, w_state;
  logic [ARB_N_REQ-1:0]        r_gnt, w_gnt;
  logic [1:0]                  r_select, w_select;
  logic [1:0]                  r_ptr, w_ptr;
  logic [c_CNT_W-1:0]          r_hold_cnt, w_hold_cnt;
  logic [2:0]                  w_pick;

  // Returns {found, id}; scanning from the far end lets the nearest hit to ptr win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] id;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      id = p + 2'(k);
      if (r[id]) rr_pick = {1'b1, id};
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_select   <= 2'd0;
      r_ptr      <= 2'd0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_gnt      <= w_gnt;
      r_select   <= w_select;
      r_ptr      <= w_ptr;
      r_hold_cnt <= w_hold_cnt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_gnt      = r_gnt;
    w_select   = r_select;
    w_ptr      = r_ptr;
    w_hold_cnt = r_hold_cnt;
    w_pick     = rr_pick(req, r_ptr);
    case (r_state)
      IDLE: begin
        w_gnt = '0;
        if (w_pick[2]) begin
          w_state    = GRANT;
          w_gnt      = 4'b0001 << w_pick[1:0];
          w_select   = w_pick[1:0];
          w_hold_cnt = '0;
          w_ptr      = w_pick[1:0] + 2'd1;
        end
      end
      GRANT: begin
        // Counter stops at the compare point, so it can never wrap.
        if (!req[r_select] || (r_hold_cnt == c_HOLD_LAST)) begin
          w_state = RELEASE;
          w_gnt   = '0;
        end else begin
          w_hold_cnt = r_hold_cnt + c_CNT_W'(1);
        end
      end
      RELEASE: begin
        w_state = IDLE;
        w_gnt   = '0;
      end
      default: begin
        w_state = IDLE;
        w_gnt   = '0;
      end
    endcase
  end

  assign gnt    = r_gnt;
  assign select = r_select;
  assign mem_en = |r_gnt;
  assign busy   = (r_state != IDLE);

  mux_4x1 #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_mux (
    .i_sel (r_select),
    .i_d0  (addr0),
    .i_d1  (addr1),
    .i_d2  (addr2),
    .i_d3  (addr3),
    .o_y   (mem_addr)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench; two arbiters (hold limits 4 and 15) vs a tenure model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [9:0] a [4];

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       en_a, en_b, busy_a, busy_b;
  logic [9:0] maddr_a, maddr_b;

  int vectors = 0;
  int errors  = 0;

  int hold_lim [2] = '{4, 15};
  int m_owner  [2];
  int m_ten    [2];
  int m_ptr    [2];
  int m_sel    [2];
  bit m_rel    [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(10), .HOLD_MAX(4)) dut_a (
    .clk(clk), .reset(reset), .req(req),
    .addr0(a[0]), .addr1(a[1]), .addr2(a[2]), .addr3(a[3]),
    .gnt(gnt_a), .select(sel_a), .mem_en(en_a), .mem_addr(maddr_a), .busy(busy_a)
  );

  mem_port_arbiter #(.ADDR_WIDTH(10), .HOLD_MAX(15)) dut_b (
    .clk(clk), .reset(reset), .req(req),
    .addr0(a[0]), .addr1(a[1]), .addr2(a[2]), .addr3(a[3]),
    .gnt(gnt_b), .select(sel_b), .mem_en(en_b), .mem_addr(maddr_b), .busy(busy_b)
  );

  // Model: an owner keeps the port for at most hold_lim cycles, then one idle turnaround cycle.
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_ten[i] = 0; m_ptr[i] = 0; m_sel[i] = 0; m_rel[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit found;
    int id;
    for (int i = 0; i < 2; i++) begin
      if (m_rel[i]) begin
        m_rel[i] = 1'b0;
      end else if (m_owner[i] >= 0) begin
        if (!req[m_owner[i]] || m_ten[i] == hold_lim[i]) begin
          m_owner[i] = -1;
          m_rel[i]   = 1'b1;
        end else begin
          m_ten[i] = m_ten[i] + 1;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          id = (m_ptr[i] + k) % 4;
          if (!found && req[id]) begin
            found = 1'b1;
            m_owner[i] = id; m_sel[i] = id; m_ten[i] = 1; m_ptr[i] = (id + 1) % 4;
          end
        end
      end
    end
  endtask

  function automatic logic [17:0] exp_vec(input int i);
    logic [3:0] g;
    g = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0000;
    return {g, 2'(m_sel[i]), |g, (m_owner[i] >= 0) || m_rel[i], a[m_sel[i]]};
  endfunction

  function automatic logic [17:0] obs_vec(input int i);
    return (i == 0) ? {gnt_a, sel_a, en_a, busy_a, maddr_a}
                    : {gnt_b, sel_b, en_b, busy_b, maddr_b};
  endfunction

  task automatic tick(input logic [3:0] r);
    req = r;
    for (int j = 0; j < 4; j++) a[j] = 10'($urandom);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs_vec(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL reset inst%0d: got %h expected %h", i, obs_vec(i), exp_vec(i));
      end
    end
    vectors++;
    if ({gnt_a, sel_a, en_a, busy_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_zero: got %h expected 00", {gnt_a, sel_a, en_a, busy_a});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_request();
    logic [3:0] pat [7];
    int hi = 0;
    pat = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      tick(pat[c]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL single c%0d inst%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      if (gnt_a == 4'b0100 && sel_a == 2'd2) hi++;
    end
    vectors++;
    if (hi !== 3) begin
      errors++;
      $display("FAIL single_tenure: got %0d cycles expected 3", hi);
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    int expo [5];
    logic [3:0] prev;
    expo = '{0, 1, 2, 3, 0};
    prev = 4'b0000;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      tick(4'b1111);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL rr c%0d inst%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      if (prev == 4'b0000 && gnt_a != 4'b0000) order.push_back(int'(sel_a));
      prev = gnt_a;
    end
    vectors++;
    if (order.size() < 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants expected 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (order[k] !== expo[k]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], expo[k]);
        end
      end
    end
  endtask

  task automatic test_pointer_skip();
    logic [3:0] pat [8];
    pat = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick(pat[c]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL ptr_skip c%0d inst%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      if (c == 4) begin
        vectors++;
        if (gnt_a !== 4'b0001) begin
          errors++;
          $display("FAIL ptr_skip_gnt: got %b expected 0001", gnt_a);
        end
      end
    end
  endtask

  task automatic test_forced_release();
    int run0 = 0;
    logic [3:0] next_g = 4'b0000;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      tick(4'b0011);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL forced c%0d inst%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      if (gnt_b == 4'b0001) begin
        run0++;
        vectors++;
        if (maddr_b !== a[0]) begin
          errors++;
          $display("FAIL forced_addr0: got %h expected %h", maddr_b, a[0]);
        end
      end
      if (gnt_b == 4'b0010 && next_g == 4'b0000) begin
        next_g = gnt_b;
        vectors++;
        if (maddr_b !== a[1]) begin
          errors++;
          $display("FAIL forced_addr1: got %h expected %h", maddr_b, a[1]);
        end
      end
    end
    vectors++;
    if (run0 !== 15 || next_g !== 4'b0010) begin
      errors++;
      $display("FAIL forced_tenure: got %0d cycles then %b expected 15 then 0010", run0, next_g);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 3; c++) tick(4'b1111);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({gnt_a, en_a, busy_a, gnt_b, en_b, busy_b} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got %h expected 000", {gnt_a, en_a, busy_a, gnt_b, en_b, busy_b});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick(4'b1000);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL async_after c%0d inst%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
    end
    vectors++;
    if (gnt_a !== 4'b1000 || sel_a !== 2'd3) begin
      errors++;
      $display("FAIL async_regrant: got %b/%0d expected 1000/3", gnt_a, sel_a);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] pat [9];
    int hi = 0;
    int rel = 0;
    pat = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      tick(pat[c]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL simul c%0d inst%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      if (gnt_a != 4'b0000) hi++;
      if (busy_a && gnt_a == 4'b0000) rel++;
    end
    vectors++;
    if (hi !== 4 || rel !== 1) begin
      errors++;
      $display("FAIL simul_tenure: got %0d grant/%0d release expected 4/1", hi, rel);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      tick(r);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random c%0d inst%0d: got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) a[j] = 10'($urandom);
    test_reset();
    test_single_request();
    test_round_robin();
    test_pointer_skip();
    test_forced_release();
    test_async_reset();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
